// File: rtl/shift_sub_divider.sv
// Restoring shift-subtract divider: 64-bit unsigned dividend by 32-bit divisor,
// one quotient bit per clock, with up-front overflow detection.
module shift_sub_divider (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        overflow,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  count_q, count_d;
    logic [31:0] r_hi_q, r_hi_d;
    logic [31:0] r_lo_q, r_lo_d;
    logic [31:0] divisor_q, divisor_d;
    logic [31:0] quotient_q, quotient_d;
    logic [31:0] remainder_q, remainder_d;
    logic        overflow_q, overflow_d;

    logic [32:0] trial;
    logic [32:0] diff;
    logic        qbit;
    logic [31:0] step_hi;
    logic [31:0] step_lo;
    logic        start_overflow;

    // One restoring step. The subtraction is 33 bits wide; because R_hi stays
    // below the divisor, bit 32 of the difference is exactly the borrow.
    always_comb begin
        trial   = {r_hi_q, r_lo_q[31]};
        diff    = trial - {1'b0, divisor_q};
        qbit    = ~diff[32];
        step_hi = qbit ? diff[31:0] : trial[31:0];
        step_lo = {r_lo_q[30:0], qbit};
    end

    assign start_overflow = (divisor == 32'd0) || (dividend[63:32] >= divisor);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        r_hi_d      = r_hi_q;
        r_lo_d      = r_lo_q;
        divisor_d   = divisor_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        overflow_d  = overflow_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    divisor_d = divisor;
                    if (start_overflow) begin
                        state_d     = DONE;
                        quotient_d  = 32'hFFFF_FFFF;
                        remainder_d = 32'h0;
                        overflow_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                        r_hi_d  = dividend[63:32];
                        r_lo_d  = dividend[31:0];
                        count_d = 6'd32;
                    end
                end
            end
            RUN: begin
                r_hi_d  = step_hi;
                r_lo_d  = step_lo;
                count_d = count_q - 6'd1;
                // Last iteration: publish the result on the same edge.
                if (count_q == 6'd1) begin
                    state_d     = DONE;
                    quotient_d  = step_lo;
                    remainder_d = step_hi;
                    overflow_d  = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= 6'd0;
            r_hi_q      <= 32'd0;
            r_lo_q      <= 32'd0;
            divisor_q   <= 32'd0;
            quotient_q  <= 32'd0;
            remainder_q <= 32'd0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            r_hi_q      <= r_hi_d;
            r_lo_q      <= r_lo_d;
            divisor_q   <= divisor_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            overflow_q  <= overflow_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed self-checking bench for shift_sub_divider: latency, results,
// overflow, ignored restarts, back-to-back starts and reset abort.
module tb_shift_sub_divider;

    logic        clk;
    logic        reset;
    logic        start;
    logic [63:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        overflow;
    logic        busy;
    logic        done;

    int checks;
    int failures;

    shift_sub_divider dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .overflow  (overflow),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start for one edge, then sample 1 time unit after each edge.
    // done_cycle is the 1-based cycle after the accepting edge where done is seen.
    task automatic run_op(input logic [63:0] dvd, input logic [31:0] dvs,
                          output int busy_cycles, output int done_cycle);
        @(negedge clk);
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start       = 1'b0;
        busy_cycles = 0;
        done_cycle  = 0;
        for (int n = 1; n <= 100; n++) begin
            if (done) begin
                done_cycle = n;
                break;
            end
            if (busy) busy_cycles++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        start    = 1'b0;
        dividend = 64'd0;
        divisor  = 32'd0;
        #2;
        checks++; if (quotient !== 32'd0)  begin failures++; $display("[TB] FAIL reset_quotient got=%h exp=0", quotient); end
        checks++; if (remainder !== 32'd0) begin failures++; $display("[TB] FAIL reset_remainder got=%h exp=0", remainder); end
        checks++; if (overflow !== 1'b0)   begin failures++; $display("[TB] FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (busy !== 1'b0)       begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)       begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_normal(input string name, input logic [63:0] dvd, input logic [31:0] dvs,
                               input logic [31:0] exp_q, input logic [31:0] exp_r);
        int bc, dc;
        run_op(dvd, dvs, bc, dc);
        checks++; if (dc !== 33)         begin failures++; $display("[TB] FAIL %s_latency got=%0d exp=33", name, dc); end
        checks++; if (bc !== 32)         begin failures++; $display("[TB] FAIL %s_busy_cycles got=%0d exp=32", name, bc); end
        checks++; if (quotient !== exp_q)  begin failures++; $display("[TB] FAIL %s_quotient got=%h exp=%h", name, quotient, exp_q); end
        checks++; if (remainder !== exp_r) begin failures++; $display("[TB] FAIL %s_remainder got=%h exp=%h", name, remainder, exp_r); end
        checks++; if (overflow !== 1'b0)   begin failures++; $display("[TB] FAIL %s_overflow got=%b exp=0", name, overflow); end
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b0)       begin failures++; $display("[TB] FAIL %s_done_one_cycle got=%b exp=0", name, done); end
        checks++; if (quotient !== exp_q)  begin failures++; $display("[TB] FAIL %s_hold_idle got=%h exp=%h", name, quotient, exp_q); end
    endtask

    task automatic test_overflow(input string name, input logic [63:0] dvd, input logic [31:0] dvs);
        int bc, dc;
        run_op(dvd, dvs, bc, dc);
        checks++; if (dc !== 1)                   begin failures++; $display("[TB] FAIL %s_latency got=%0d exp=1", name, dc); end
        checks++; if (bc !== 0)                   begin failures++; $display("[TB] FAIL %s_busy_cycles got=%0d exp=0", name, bc); end
        checks++; if (quotient !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL %s_quotient got=%h exp=ffffffff", name, quotient); end
        checks++; if (remainder !== 32'd0)        begin failures++; $display("[TB] FAIL %s_remainder got=%h exp=0", name, remainder); end
        checks++; if (overflow !== 1'b1)          begin failures++; $display("[TB] FAIL %s_overflow got=%b exp=1", name, overflow); end
        @(posedge clk);
        #1;
    endtask

    // Restart at RUN cycle 5 with new operands must be ignored; outputs must
    // keep the previous result (4*2^32/5 -> cccccccc r4) while running.
    task automatic test_ignore_start();
        int dones, first_done;
        @(negedge clk);
        dividend = 64'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        dividend   = 64'd1000;
        divisor    = 32'd3;
        dones      = 0;
        first_done = 0;
        for (int n = 1; n <= 45; n++) begin
            if (n == 5) start = 1'b1;
            if (n == 6) start = 1'b0;
            if (n == 10) begin
                checks++; if (quotient !== 32'hCCCC_CCCC) begin failures++; $display("[TB] FAIL ign_hold_run_q got=%h exp=cccccccc", quotient); end
                checks++; if (remainder !== 32'd4)        begin failures++; $display("[TB] FAIL ign_hold_run_r got=%h exp=4", remainder); end
            end
            if (done) begin
                dones++;
                if (first_done == 0) begin
                    first_done = n;
                    checks++; if (quotient !== 32'd14) begin failures++; $display("[TB] FAIL ign_quotient got=%h exp=e", quotient); end
                    checks++; if (remainder !== 32'd2) begin failures++; $display("[TB] FAIL ign_remainder got=%h exp=2", remainder); end
                end
            end
            @(posedge clk);
            #1;
        end
        checks++; if (first_done !== 33) begin failures++; $display("[TB] FAIL ign_latency got=%0d exp=33", first_done); end
        checks++; if (dones !== 1)       begin failures++; $display("[TB] FAIL ign_done_count got=%0d exp=1", dones); end
    endtask

    // start held high: second acceptance is the IDLE cycle after DONE, so the
    // second done lands 34 cycles after the first.
    task automatic test_back_to_back();
        int dones;
        int done_at [2];
        @(negedge clk);
        dividend = 64'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        dones      = 0;
        done_at[0] = 0;
        done_at[1] = 0;
        for (int n = 1; n <= 80 && dones < 2; n++) begin
            if (done) begin
                done_at[dones] = n;
                if (dones == 0) begin
                    checks++; if (quotient !== 32'd14) begin failures++; $display("[TB] FAIL b2b_first_q got=%h exp=e", quotient); end
                    dividend = 64'h0000_0003_0000_0005;
                    divisor  = 32'd4;
                end else begin
                    checks++; if (quotient !== 32'hC000_0001) begin failures++; $display("[TB] FAIL b2b_second_q got=%h exp=c0000001", quotient); end
                    checks++; if (remainder !== 32'd1)        begin failures++; $display("[TB] FAIL b2b_second_r got=%h exp=1", remainder); end
                end
                dones++;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        checks++; if (done_at[0] !== 33) begin failures++; $display("[TB] FAIL b2b_first_latency got=%0d exp=33", done_at[0]); end
        checks++; if (done_at[1] !== 67) begin failures++; $display("[TB] FAIL b2b_second_latency got=%0d exp=67", done_at[1]); end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset_abort();
        int dones;
        @(negedge clk);
        dividend = 64'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++; if (quotient !== 32'd0)  begin failures++; $display("[TB] FAIL abort_quotient got=%h exp=0", quotient); end
        checks++; if (remainder !== 32'd0) begin failures++; $display("[TB] FAIL abort_remainder got=%h exp=0", remainder); end
        checks++; if (overflow !== 1'b0)   begin failures++; $display("[TB] FAIL abort_overflow got=%b exp=0", overflow); end
        checks++; if (busy !== 1'b0)       begin failures++; $display("[TB] FAIL abort_busy got=%b exp=0", busy); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        checks++; if (dones !== 0) begin failures++; $display("[TB] FAIL abort_no_done got=%0d exp=0", dones); end
        test_normal("post_reset", 64'h0000_0001_0000_0000, 32'd2, 32'h8000_0000, 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_normal("div100_7", 64'd100, 32'd7, 32'd14, 32'd2);
        test_normal("max_product", 64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
        test_normal("small", 64'd5, 32'd9, 32'd0, 32'd5);
        test_overflow("div_zero", 64'd1234, 32'd0);
        test_overflow("hi_eq_div", 64'h0000_0005_0000_0000, 32'd5);
        test_normal("hi_below_div", 64'h0000_0004_0000_0000, 32'd5, 32'hCCCC_CCCC, 32'd4);
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
